// File: rtl/tdm_demux4.sv
// tdm_demux4 -- receive end of a SLOTS:1 time-division mux link.
//
// Collects one WIDTH-bit beat per slot from a shared line. A beat flagged
// with `sync` is slot 0. When the last slot arrives, the rebuilt
// SLOTS*WIDTH word is presented on `dout` in a single update.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   din         slot data (the external mux output)
//   din_valid   din carries a beat this cycle
//   sync        current beat is slot 0 (ignored when din_valid=0)
//   sel         slot expected next (drives the external mux select)
//   dout        last complete frame, slot k at dout[k*WIDTH +: WIDTH]
//   dout_valid  one-cycle pulse when dout updates
//   locked      frame alignment held
//   sync_err    one-cycle pulse on an alignment error
//
// Build option: TDM_DEMUX_STRICT_SYNC_EN. When it is defined, a slot-0 beat
// in RUN that arrives without `sync` is treated as loss of alignment and the
// receiver drops back to IDLE. When it is undefined, such a beat is accepted
// as a free-running slot 0.
module tdm_demux4 #(
  parameter int WIDTH = 1,
  parameter int SLOTS = 4,
  parameter int SEL_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic                   din_valid,
  input  logic                   sync,
  output logic [SEL_W-1:0]       sel,
  output logic [SLOTS*WIDTH-1:0] dout,
  output logic                   dout_valid,
  output logic                   locked,
  output logic                   sync_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(SLOTS - 1);

  state_t                     state, nxt_state;
  logic [SEL_W-1:0]           slot;
  logic [SLOTS-1:0][WIDTH-1:0] shadow;

  // Per-cycle actions decoded from state and inputs.
  logic start;   // beat becomes slot 0 of a fresh frame
  logic beat;    // beat stored at the current slot
  logic err;     // alignment error this cycle
  logic abort;   // drop alignment and return to IDLE
  logic complete;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: if (din_valid && sync) nxt_state = RUN;
      RUN: begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
        if (din_valid && !sync && slot == '0) nxt_state = IDLE;
`endif
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Action decode
  always_comb begin
    start = 1'b0;
    beat  = 1'b0;
    err   = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: start = din_valid && sync;   // unsynced beats are dropped
      RUN: begin
        if (din_valid) begin
          if (sync) begin
            // sync mid-frame restarts the frame on this beat
            start = 1'b1;
            err   = (slot != '0);
          end else if (slot == '0) begin
`ifdef TDM_DEMUX_STRICT_SYNC_EN
            err   = 1'b1;
            abort = 1'b1;
`else
            beat  = 1'b1;
`endif
          end else begin
            beat = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign complete = beat && (slot == LAST);

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      slot       <= '0;
      shadow     <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      sync_err   <= err;
      if (start) begin
        // Clearing drops any partial frame; slot 0 then takes this beat.
        shadow    <= '0;
        shadow[0] <= din;
        slot      <= SEL_W'(1);
        locked    <= 1'b1;
      end
      if (beat) begin
        shadow[slot] <= din;
        slot         <= slot + 1'b1;  // wraps to 0 after the last slot
        if (complete) begin
          // Last slot goes straight to dout, so no extra cycle is spent.
          dout       <= {din, shadow[SLOTS-2:0]};
          dout_valid <= 1'b1;
        end
      end
      if (abort) begin
        shadow <= '0;
        slot   <= '0;
        locked <= 1'b0;
      end
    end
  end

  assign sel = slot;

endmodule

// File: doc/tdm_demux4.md
Name: tdm_demux4

Overview:
- Time-division demultiplexer; the receive end of a 4:1 mux link.
- Accepts one data beat per slot on a shared line and rebuilds the parallel word, with slot 0 marked by `sync`.
- Drives `sel` so it can scan an external mux; after a frame it presents the reconstructed word atomically.
- Sits between a mux-based serialising path and downstream parallel logic.

Parameters:
- WIDTH, 1, data bits per slot.
- SLOTS, 4, slots per frame; must equal 2**SEL_W.
- SEL_W, 2, slot counter / `sel` width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  slot data (mux output `y`).
- din_valid  input  1  `din` carries a beat this cycle.
- sync  input  1  qualifies the current beat as slot 0; ignored when `din_valid`=0.
- sel  output  SEL_W  slot expected next; equals internal slot counter.
- dout  output  SLOTS*WIDTH  last complete frame; slot k at `dout[k*WIDTH +: WIDTH]`.
- dout_valid  output  1  one-cycle pulse when `dout` updates.
- locked  output  1  frame alignment held.
- sync_err  output  1  one-cycle pulse on alignment error.

Behaviour:
- Reset: state IDLE, slot=0, shadow=0, `dout`=0, `dout_valid`=0, `locked`=0, `sync_err`=0. A reset mid-frame discards the partial frame; `dout` is cleared.
- States:
  - IDLE: beats without `sync` are dropped. On `din_valid`&`sync`: shadow[0]<=`din`, slot<=1, `locked`<=1, go to RUN.
  - RUN, `din_valid`&!`sync`: shadow[slot]<=`din`, slot<=slot+1.
  - RUN, `din_valid`&`sync`&slot==0: normal frame start, handled as above.
  - RUN, `din_valid`&`sync`&slot!=0: `sync_err` pulses next cycle. Partial shadow is cleared, beat is stored as slot 0, slot<=1, stay in RUN, no `dout_valid`.
  - RUN, slot 0 beat without `sync`: accepted as slot 0 (free-running after lock).
- Frame completion: the beat at slot==SLOTS-1 completes the frame. Next cycle `dout`<={`din`, shadow[SLOTS-2:0]} and `dout_valid`=1 for exactly one cycle; slot wraps to 0. Latency is 1 clk from the last beat to `dout`.
- `din_valid`=0: no state change; `dout` holds; outputs registered.
- Back-to-back frames with `din_valid` held high sustain 1 frame per SLOTS cycles; `dout_valid` pulses every SLOTS cycles.
- Slot counter wraps naturally at SEL_W bits; no arithmetic past SLOTS-1.
- `sel` changes only on accepted beats, so an external mux sees a stable `sel` between beats.

Optional Feature:
- Macro TDM_DEMUX_STRICT_SYNC_EN.
- Defined: in RUN, a slot 0 beat without `sync` is an error. `sync_err` pulses, the beat is dropped, shadow is cleared, `locked`<=0, slot<=0, go to IDLE.
- Undefined: such a beat is accepted (free-running), as described in Behaviour.

Test Plan:
- Reset then beats 1,0,1,1 (`sync` on first, `din_valid`=1 continuous) -> `dout`=4'b1101 one cycle after 4th beat; `dout_valid` high 1 cycle; `locked`=1; `sel` sequence 0,1,2,3,0.
- Before any `sync`, 3 beats of 1 then `sync` frame 0,1,0,0 -> early beats ignored; `dout`=4'b0010; `locked` 0 until the `sync` beat.
- Frame with `din_valid` gaps of 2 idle cycles between beats, data 1,1,1,0 -> `dout`=4'b0111, `sel` stable during gaps, single `dout_valid`.
- `sync` re-asserted at slot 2 (beats 1,1,`sync`+0,1,1,1) -> `sync_err` pulse, no `dout_valid` for the broken frame; next `dout`=4'b1110.
- `rst` asserted after 2 beats -> `dout`=0, `locked`=0, slot=0; the following full frame 0,0,0,1 gives `dout`=4'b1000.
- Two frames, second frame without `sync` (0,1,1,0) -> default build: `dout`=4'b0110; with TDM_DEMUX_STRICT_SYNC_EN: `sync_err` pulse, `locked`=0, no second `dout_valid`.
